// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer for the shared 64-bit memory port.
// Partial stores become read-modify-write; the block drives mem_data only while mem_rw is high.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_ack,
    output logic [63:0] i_rdata,
    input  logic        d_req,
    input  logic [63:0] d_addr,
    input  logic        d_we,
    input  logic [7:0]  d_be,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_rw,
    inout  wire  [63:0] mem_data
);
    typedef enum logic [1:0] {IDLE, RD, RMW_RD, WR} state_t;

    typedef struct packed {
        logic        port_d;
        logic [7:0]  be;
        logic [63:0] wdata;
    } req_t;

    state_t      state;
    req_t        cur;
    logic        last_d;
    logic [63:0] wr_q;
    logic        grant_any;
    logic        grant_d;
    logic [63:0] merged;
    logic        unused;

    assign unused = ^{i_addr[2:0], d_addr[2:0]};

    // Output enable shares the mem_rw flop, so block and memory never drive together.
    assign mem_data = mem_rw ? wr_q : 64'bz;

    always_comb begin
        // Dead cycle after every ack keeps a registered requester from double-granting.
        grant_any = (i_req | d_req) & ~i_ack & ~d_ack;
        grant_d   = d_req & (~i_req | ~last_d);
        merged    = '0;
        for (int n = 0; n < 8; n++)
            merged[8*n +: 8] = cur.be[n] ? cur.wdata[8*n +: 8] : mem_data[8*n +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_rw   <= 1'b0;
            mem_addr <= '0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            last_d   <= 1'b0;
            cur      <= '0;
            wr_q     <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_d <= grant_d;
                        if (grant_d) begin
                            mem_addr <= {d_addr[63:3], 3'b000};
                            cur      <= '{port_d: 1'b1, be: d_be, wdata: d_wdata};
                            if (d_we && d_be == 8'hFF) begin
                                state  <= WR;
                                mem_rw <= 1'b1;
                                wr_q   <= d_wdata;
                            end else if (d_we && d_be != 8'h00) begin
                                state <= RMW_RD;
                            end else begin
                                state <= RD;
                            end
                        end else begin
                            mem_addr <= {i_addr[63:3], 3'b000};
                            cur      <= '{port_d: 1'b0, be: 8'h00, wdata: 64'h0};
                            state    <= RD;
                        end
                    end
                end
                RD: begin
                    if (cur.port_d) begin
                        d_rdata <= mem_data;
                        d_ack   <= 1'b1;
                    end else begin
                        i_rdata <= mem_data;
                        i_ack   <= 1'b1;
                    end
                    state <= IDLE;
                end
                RMW_RD: begin
                    wr_q   <= merged;
                    mem_rw <= 1'b1;
                    state  <= WR;
                end
                WR: begin
                    d_ack  <= 1'b1;
                    mem_rw <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the 64-bit word-addressed SOC memory. It shares the single memory port (negedge-clocked, `rw`-selected read/write over a bidirectional data bus) between the CPU instruction-fetch port (read-only) and the data load/store port (read/write with byte enables). Partial-word stores become read-modify-write sequences, and the block owns the tristate discipline on the shared data bus.

## Interface
- No parameters; all widths are fixed at 64-bit address and 64-bit data.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all block state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  instruction-fetch request; held high until `i_ack`.
- `i_addr`  in  64  fetch byte address; bits [2:0] are ignored.
- `i_ack`  out  1  one-cycle completion pulse for the fetch.
- `i_rdata`  out  64  fetched word; valid while `i_ack`=1, held until the next `i_ack`.
- `d_req`  in  1  data request; held high with stable addr/we/be/wdata until `d_ack`.
- `d_addr`  in  64  data byte address; bits [2:0] are ignored.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  8  store byte enables, bit n selects byte lane [8n+7:8n]; ignored for loads.
- `d_wdata`  in  64  store data.
- `d_ack`  out  1  one-cycle completion pulse for the data access.
- `d_rdata`  out  64  loaded word; valid while `d_ack`=1 for loads, held otherwise.
- `mem_addr`  out  64  memory address; bits [2:0] are always 0.
- `mem_rw`  out  1  memory write strobe; 1 = write, 0 = read.
- `mem_data`  inout  64  shared data bus; the block drives it only while `mem_rw`=1 and leaves it high-Z otherwise.

## Operation
- States: IDLE, RD, RMW_RD, WR.
- **IDLE**
  - Requests are sampled only when neither ack output is high. This gives one dead cycle after every ack, so a registered requester that drops `req` on the ack edge is never granted twice.
  - If both ports request, the port not granted last wins. The last-grant register resets to instruction, so the first tie goes to data.
  - On grant, register `mem_addr` = {addr[63:3], 3'b000} and latch the port id, we, be and wdata.
- **Grant transitions**
  - Instruction grant, data load, or data store with `d_be`=8'h00: go to RD with `mem_rw`=0. A zero-mask store touches no memory; it is acked like a load, and `d_rdata` is updated.
  - Data store with `d_be`=8'hFF: go to WR with `mem_rw`=1 and `mem_data` = wdata.
  - Data store with any other `d_be`: go to RMW_RD with `mem_rw`=0.
- **RD**
  - Capture `mem_data` into the granted port's rdata register.
  - Pulse that port's ack and return to IDLE with `mem_rw`=0.
- **RMW_RD**
  - Capture `mem_data`.
  - Merge per lane: be[n] ? wdata lane : memory lane.
  - Go to WR with `mem_rw`=1 and `mem_data` = merged word; `mem_addr` is unchanged.
- **WR**
  - Pulse `d_ack`, set `mem_rw`=0 and return to IDLE.
  - `mem_rw` is high for exactly one cycle per write, so the memory writes on exactly one falling edge.
- **Bus ownership:** the memory drives the bus whenever `mem_rw`=0. The block's output enable and `mem_rw` come from the same flop, so there is never a cycle with two drivers.

## Timing
- **Reset values:** state IDLE; `mem_rw`=0; `mem_addr`=0; `mem_data` high-Z; `i_ack`=`d_ack`=0; `i_rdata`=`d_rdata`=0; last-grant = instruction.
- **Read / full store:** grant at edge P0; memory acts on the falling edge between P0 and P1; ack is high during the cycle P1–P2.
- **Read data path:** the memory registers read data at the falling edge, and the block samples it at P1.
- **Partial store:** grant at P0, RMW_RD during P0–P1, WR during P1–P2, `d_ack` during P2–P3.
- **Throughput:** at most one access per 3 cycles for reads and full stores, 4 cycles for partial stores.
- **Reset mid-transaction:** the in-flight transaction is aborted with no ack. `mem_rw` returns to 0 at the same edge.
  - A write whose WR cycle has already passed its falling edge stays written.
  - A write not yet in WR never reaches memory.
- **Request withdrawal:** a requester that drops `req` before ack violates protocol; the block completes the access anyway.

## Test plan
- **Reset:** assert `reset` for 2 cycles with both reqs high -> all outputs at reset values, no ack, `mem_rw`=0, bus high-Z; first ack appears 2 cycles after reset is released.
- **Fetch:** memory word 0 preloaded with 64'h00000000_00100073; `i_req`, `i_addr`=0x5 -> `mem_addr`=0, `i_ack` one cycle later with `i_rdata`=64'h00000000_00100073.
- **Full store then load:** store `d_addr`=0x10, `d_be`=8'hFF, data 64'hDEADBEEF_CAFEF00D -> `mem_rw` high for exactly 1 cycle and `d_ack` next cycle; a load from 0x10 then returns that value.
- **Partial store:** word 0x10 = 64'h11223344_55667788; store with `d_be`=8'h0F, data 64'hAAAAAAAA_BBBBBBBB -> RMW sequence, `d_ack` at P2, readback 64'h11223344_BBBBBBBB; a store with `d_be`=8'h00 leaves memory unchanged.
- **Contention:** `i_req` and `d_req` held continuously -> grants alternate D, I, D, I, with one dead cycle after each ack; no port waits more than one foreign access.
- **Reset during partial store:** assert `reset` in the RMW_RD cycle -> no `d_ack`, `mem_rw` never high, memory word unchanged.
